// File: rtl/digit_entry.sv
// digit_entry: player-side code entry for the memorization game.
// Collects four digits (0..DIGIT_MAX, one nibble each) from the switch bank.
// A digit is taken on each debounced press of btn_enter. The first digit
// lands in userInt[15:12].
// Optional feature macro: ENTRY_TIMEOUT_EN. When defined, an idle ENTRY
// session times out back to IDLE and pulses timeout. When undefined,
// timeout is constant 0 and ENTRY waits indefinitely.
//
// Handshake: start and clear are single-cycle request pulses with no ready
// side. They are honoured on the clock edge where they are high.
// entry_done, digit_err and timeout are single-cycle, registered status
// pulses with no back-pressure.
module digit_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned DIGIT_MAX       = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 500000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        clear,
  input  logic [3:0]  sw,
  input  logic        btn_enter,
  output logic [15:0] userInt,
  output logic [2:0]  digit_cnt,
  output logic        busy,
  output logic        entry_done,
  output logic        digit_err,
  output logic        timeout,
  output logic [1:0]  fsm_state
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stable_d;
  logic [DW-1:0] db_cnt;
  logic          press;

  assign fsm_state = state;

  // Two-flop synchroniser for the raw, asynchronous push-button.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_enter;
      sync2 <= sync1;
    end
  end

  // Debounce: accept a new level only after it has differed from the
  // stable level for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable <= 1'b0;
      db_cnt <= '0;
    end else if (sync2 != stable) begin
      if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Registered press pulse, one cycle after the stable level rises.
  // Releases give nothing, so a held button yields a single digit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_d <= 1'b0;
      press    <= 1'b0;
    end else begin
      stable_d <= stable;
      press    <= stable & ~stable_d;
    end
  end

`ifdef ENTRY_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] to_cnt;

  // Entry FSM with the idle-entry timeout. Start always wins over a timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      userInt    <= '0;
      digit_cnt  <= '0;
      busy       <= 1'b0;
      entry_done <= 1'b0;
      digit_err  <= 1'b0;
      timeout    <= 1'b0;
      to_cnt     <= '0;
    end else begin
      entry_done <= 1'b0;
      digit_err  <= 1'b0;
      timeout    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ENTRY;
            busy      <= 1'b1;
            userInt   <= '0;
            digit_cnt <= '0;
            to_cnt    <= '0;
          end
        end
        ENTRY: begin
          if (start || clear) begin
            userInt   <= '0;
            digit_cnt <= '0;
            to_cnt    <= '0;
          end else if (press) begin
            to_cnt <= '0;
            if (sw <= 4'(DIGIT_MAX)) begin
              userInt   <= {userInt[11:0], sw};
              digit_cnt <= digit_cnt + 3'd1;
              if (digit_cnt == 3'd3) begin
                state      <= DONE;
                busy       <= 1'b0;
                entry_done <= 1'b1;
              end
            end else begin
              digit_err <= 1'b1;
            end
          end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state     <= IDLE;
            busy      <= 1'b0;
            userInt   <= '0;
            digit_cnt <= '0;
            timeout   <= 1'b1;
            to_cnt    <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            state     <= ENTRY;
            busy      <= 1'b1;
            userInt   <= '0;
            digit_cnt <= '0;
            to_cnt    <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
`else
  assign timeout = 1'b0;

  // Entry FSM: arm on start, shift in digits on valid presses, finish on
  // the fourth digit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      userInt    <= '0;
      digit_cnt  <= '0;
      busy       <= 1'b0;
      entry_done <= 1'b0;
      digit_err  <= 1'b0;
    end else begin
      entry_done <= 1'b0;
      digit_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ENTRY;
            busy      <= 1'b1;
            userInt   <= '0;
            digit_cnt <= '0;
          end
        end
        ENTRY: begin
          if (start || clear) begin
            userInt   <= '0;
            digit_cnt <= '0;
          end else if (press) begin
            if (sw <= 4'(DIGIT_MAX)) begin
              userInt   <= {userInt[11:0], sw};
              digit_cnt <= digit_cnt + 3'd1;
              if (digit_cnt == 3'd3) begin
                state      <= DONE;
                busy       <= 1'b0;
                entry_done <= 1'b1;
              end
            end else begin
              digit_err <= 1'b1;
            end
          end
        end
        DONE: begin
          if (start) begin
            state     <= ENTRY;
            busy      <= 1'b1;
            userInt   <= '0;
            digit_cnt <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
`endif

endmodule

// File: doc/digit_entry.md
Name: digit_entry

Overview:
- Player-side input collector for the memorization game.
- Assembles a 4-digit code (each digit 0..8, one nibble) from a switch bank and a raw push-button, and presents it as userInt[15:0] for comparison against the generated target.
- Sits between the board I/O and the comparator. Armed by the game controller with start; reports completion with entry_done.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive cycles btn_enter must hold a new level before it is accepted.
- DIGIT_MAX, 8: largest legal digit value. Larger values are rejected.
- TIMEOUT_CYCLES, 500000000: idle-entry limit. Used only with ENTRY_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  synchronous 1-cycle pulse from the controller; arms or restarts entry.
- clear  input  1  synchronous 1-cycle pulse; discards digits entered so far.
- sw  input  4  digit value from the switches; sampled when an enter press is accepted.
- btn_enter  input  1  raw, asynchronous, active-high push-button.
- userInt  output  16  assembled code.
- digit_cnt  output  3  number of digits accepted, 0..4.
- busy  output  1  high while in ENTRY.
- entry_done  output  1  1-cycle pulse when the 4th digit is accepted.
- digit_err  output  1  1-cycle pulse when a press carries sw > DIGIT_MAX.
- timeout  output  1  1-cycle pulse on entry timeout. Tied 0 without ENTRY_TIMEOUT_EN.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; userInt=0, digit_cnt=0, busy=0, entry_done=0, digit_err=0, timeout=0; debounce stable level=0, counters=0. Reset mid-entry discards all progress.
- btn_enter input path:
  - 2-flop synchroniser, then debounce.
  - The debounce counter increments while the synchronised level differs from the stable level, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, the stable level is updated.
  - A stable 0->1 transition produces a 1-cycle press pulse. Releases produce nothing.
- FSM states: IDLE, ENTRY, DONE.
  - IDLE: busy=0. start -> ENTRY; userInt=0, digit_cnt=0. Presses are ignored.
  - ENTRY: busy=1. Rules evaluated per cycle, highest priority first:
    1. start: restart (userInt=0, digit_cnt=0, stay ENTRY).
    2. clear: userInt=0, digit_cnt=0, stay ENTRY. A press in the same cycle is dropped.
    3. press with sw<=DIGIT_MAX: userInt <= {userInt[11:0], sw}, digit_cnt+1. The first digit ends up in [15:12]. If digit_cnt becomes 4: -> DONE, and entry_done=1 in that same registered update, for one cycle only.
    4. press with sw>DIGIT_MAX: digit_err=1 for one cycle; userInt and digit_cnt unchanged.
  - DONE: busy=0. userInt and digit_cnt (=4) hold. Presses and clear are ignored. start -> ENTRY with a fresh clear.
- Latency: the press pulse is one cycle after the stable level updates. userInt/digit_cnt update on the cycle after the press pulse.
- Outputs are registered; no combinational path from input to output.
- A held button yields exactly one digit. A new digit requires release plus a debounced re-press.

Optional Feature:
- Macro: ENTRY_TIMEOUT_EN.
- Defined:
  - A counter runs in ENTRY. It is cleared on entering ENTRY, on start, clear, and any press (valid or invalid).
  - On reaching TIMEOUT_CYCLES-1: -> IDLE; userInt=0, digit_cnt=0; timeout=1 for one cycle.
  - start in the same cycle wins, and no timeout pulse is produced.
- Undefined: no counter logic; timeout is constant 0; ENTRY waits indefinitely.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64):
1. Reset: start, accept 2 digits, drive rst=0 for 3 cycles -> all outputs 0, busy=0. A press after release is ignored until start.
2. start; clean presses with sw=3,7,0,8 -> userInt=16'h3708, digit_cnt=4, entry_done high exactly 1 cycle, busy=0. Further presses leave userInt unchanged.
3. In ENTRY, press with sw=9 -> digit_err 1 cycle; digit_cnt and userInt unchanged. Then sw=5 -> userInt=16'h0005, digit_cnt=1.
4. Bounce: btn_enter toggles every 2 cycles for 12 cycles, then held 20 cycles with sw=6 -> exactly one digit accepted; userInt=16'h0006.
5. Enter 5,1; clear asserted in the same cycle as a press pulse -> userInt=0, digit_cnt=0. Then 2,2,2,2 -> userInt=16'h2222, entry_done pulse.
6. With ENTRY_TIMEOUT_EN: start, no presses for 64 cycles -> timeout 1 cycle, busy=0, userInt=0. Without the macro: busy stays 1 and timeout stays 0.
